half_handshake_rx: RTL
======================

# half_handshake_rx

Receive-side endpoint of the half-handshake crossing, running entirely in the receive clock domain. It synchronises the level request `tready_trndom` from the transmit domain and captures `data_trndom` on each new request. It answers with a fixed-length `rack` acknowledge and presents the captured word downstream on a valid/ready interface. Downstream backpressure stalls the acknowledge, which in turn stalls the transmitter.

## Interface
- `DATA_W`, 32, width of the transferred word
- `SYNC_STAGES`, 2, flops in the request synchroniser; must be ≥ 2
- `ACK_CYCLES`, 2, cycles `rack` stays high per transfer; must be ≥ 1

- `clk_receive`  in  1  receive-domain clock; the only clock
- `rst_receive`  in  1  asynchronous, active-low reset
- `tready_trndom`  in  1  request level from the transmit domain; asynchronous to `clk_receive`
- `data_trndom`  in  DATA_W  transmit-domain data; stable while `tready_trndom` is high
- `rack`  out  1  acknowledge to the transmit domain
- `data_revdom`  out  DATA_W  captured word
- `rvalid`  out  1  `data_revdom` holds a word not yet accepted
- `rready`  in  1  downstream accepts the word when `rvalid && rready`
- `proto_err`  out  1  sticky protocol-error flag; present only with the macro

## Operation
- **Synchroniser:** `tready_trndom` passes through a SYNC_STAGES-flop chain, giving `req_s`. The registered copy `req_d` gives `rise = req_s & ~req_d` and `fall = ~req_s & req_d`.
- **Capture condition:** `(rise | pending) & (~rvalid | rready)`.
- **On capture:**
  - `data_revdom <= data_trndom` and `rvalid <= 1`.
  - `pending <= 0`.
  - FSM goes to RX_ACK and the ack counter loads ACK_CYCLES-1.
- **Output buffer occupied:** if `rise` occurs while `rvalid && !rready`, set `pending <= 1`. No acknowledge is given, so the transmitter keeps the data stable.
- **Downstream accept:** `rvalid && rready` with no capture clears `rvalid`. Accept and capture on the same edge loads the new word with `rvalid` staying 1 (zero bubble).
- **FSM states:**
  - RX_IDLE: `rack = 0`.
  - RX_ACK: `rack = 1`; the counter decrements each cycle. At 0 the FSM returns to RX_IDLE, regardless of request level (half handshake: the ack is not held until the request drops).
  - A capture while in RX_ACK reloads the counter and the FSM stays in RX_ACK.
- **Request drop while pending:** `fall` with `pending = 1` clears `pending` (transfer abandoned, nothing captured).
- **Edge rule:** a new transfer requires `req_s` to be seen low and then high again. A request held high produces exactly one capture.

## Timing
- **Reset values:**
  - `rack = 0`, `rvalid = 0`, `data_revdom = 0`, `proto_err = 0`.
  - Synchroniser, `req_d` and `pending` cleared; FSM in RX_IDLE.
- **Latency:** take edge k as the first edge sampling `tready_trndom` high. With the buffer free, `rvalid` and `rack` rise at edge k+SYNC_STAGES.
- **Ack length:** `rack` high for exactly ACK_CYCLES cycles per capture, unless extended by a back-to-back capture.
- **Throughput:** one transfer per 2·SYNC_STAGES+2 cycles minimum, limited by request toggling.
- **Reset mid-operation:** all state is cleared immediately (asynchronous). If `tready_trndom` is high when reset releases, the chain fills from 0, a `rise` is seen, and the word is captured again. Duplication across reset is accepted.
- **Ready while empty:** `rready` with `rvalid = 0` is ignored.

## Configuration
- `HALF_HANDSHAKE_RX_PROTO_CHK_EN`
- **Defined:** `proto_err` port exists. It sets on `fall` while `pending = 1`, or on `rise` while in RX_ACK, and clears only on reset.
- **Undefined:** no `proto_err` port and no checker logic. Capture and ack behaviour is identical in both builds.

## Structure
- **`half_handshake_pkg`** holds:
  - `rx_state_t` enum {RX_IDLE, RX_ACK}
  - default `DATA_W` constant
  - minimum `SYNC_STAGES` constant (2)
- **`cdc_sync_bit` sub-module:** parameterised STAGES-deep single-bit synchroniser with async active-low reset. It is reused by the transmit side for `rack`.

## Test plan
- Reset release, `rready = 1`, `tready_trndom` rises with `data_trndom = 32'hDEAD_BEEF` → `rvalid` and `rack` high at edge k+2, `data_revdom = 32'hDEAD_BEEF`, `rack` high exactly 2 cycles.
- Hold `tready_trndom` high for 20 cycles → exactly one capture and one `rack` pulse.
- `rready = 0` with a word buffered, second request with `32'h1234_5678` → no `rack`, `pending = 1`. Raise `rready` → capture on the same edge, `rvalid` stays 1, `data_revdom = 32'h1234_5678`, `rack` follows.
- With the macro defined: pending request, then drop `tready_trndom` before `rready` → no capture, `pending` cleared, `proto_err = 1` until reset.
- Assert `rst_receive` low while `rack` and `rvalid` are high → both 0 asynchronously. Release with `tready_trndom` still high → recapture at edge k+2.

Source files
------------

// File: rtl/half_handshake_pkg.sv
// half_handshake_pkg: shared types and constants for the half-handshake crossing.
//   rx_state_t      : receive-side acknowledge FSM states
//   DATA_W_DEF      : default transferred word width
//   SYNC_STAGES_MIN : minimum synchroniser depth for a safe crossing
package half_handshake_pkg;
   typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;
   localparam int DATA_W_DEF      = 32;
   localparam int SYNC_STAGES_MIN = 2;
endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: STAGES-deep single-bit synchroniser with async active-low reset.
//   clk_i  : destination-domain clock
//   rst_ni : asynchronous active-low reset, clears the chain
//   d_i    : bit from the foreign clock domain
//   q_o    : synchronised bit, STAGES cycles behind d_i
module cdc_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] sync_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) sync_q <= '0;
      else         sync_q <= {sync_q[STAGES-2:0], d_i};
   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/half_handshake_rx.sv
// half_handshake_rx: receive endpoint of the half-handshake crossing.
//   clk_receive   : receive-domain clock (only clock)
//   rst_receive   : asynchronous active-low reset
//   tready_trndom : request level from the transmit domain (asynchronous)
//   data_trndom   : transmit-domain word, stable while the request is high
//   rack          : fixed-length acknowledge back to the transmit domain
//   data_revdom   : captured word
//   rvalid        : data_revdom holds a word not yet accepted
//   rready        : downstream accepts when rvalid && rready
//   proto_err     : sticky protocol error, only with HALF_HANDSHAKE_RX_PROTO_CHK_EN
module half_handshake_rx
   import half_handshake_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int ACK_CYCLES  = 2
) (
   input  logic              clk_receive,
   input  logic              rst_receive,
   input  logic              tready_trndom,
   input  logic [DATA_W-1:0] data_trndom,
   output logic              rack,
   output logic [DATA_W-1:0] data_revdom,
   output logic              rvalid,
   input  logic              rready
`ifdef HALF_HANDSHAKE_RX_PROTO_CHK_EN
   ,
   output logic              proto_err
`endif
);
   localparam int CNT_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_CYCLES - 1);

   if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (ACK_CYCLES < 1) begin : g_bad_ack
      $error("ACK_CYCLES must be at least 1");
   end

   logic              req_s, req_d_q, rise, fall, capture;
   logic              pending_q, pending_d, rvalid_q, rvalid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   rx_state_t         state_q, state_d;

   cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk_i  (clk_receive),
      .rst_ni (rst_receive),
      .d_i    (tready_trndom),
      .q_o    (req_s)
   );

   assign rise = req_s & ~req_d_q;
   assign fall = ~req_s & req_d_q;

   // A buffered request is only taken once the output slot frees; until then
   // no ack is given, so the transmitter keeps data_trndom stable.
   always_comb begin
      capture   = (rise | pending_q) & (~rvalid_q | rready);
      pending_d = capture ? 1'b0 : (fall & pending_q) ? 1'b0 :
                  (rise & rvalid_q & ~rready) ? 1'b1 : pending_q;
      rvalid_d  = capture | (rvalid_q & ~rready);
      data_d    = capture ? data_trndom : data_q;
   end

   always_ff @(posedge clk_receive or negedge rst_receive)
      if (!rst_receive) begin
         req_d_q   <= 1'b0;
         pending_q <= 1'b0;
         rvalid_q  <= 1'b0;
         data_q    <= '0;
      end else begin
         req_d_q   <= req_s;
         pending_q <= pending_d;
         rvalid_q  <= rvalid_d;
         data_q    <= data_d;
      end

   always_ff @(posedge clk_receive or negedge rst_receive)
      if (!rst_receive) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end

   // The ack times out on its own; the request level is not consulted.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (capture) begin
         state_d = RX_ACK;
         cnt_d   = ACK_LOAD;
      end else if (state_q == RX_ACK) begin
         state_d = (cnt_q == '0) ? RX_IDLE : RX_ACK;
         cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
   end

   always_comb begin
      rack = (state_q == RX_ACK);
   end

   assign rvalid      = rvalid_q;
   assign data_revdom = data_q;

`ifdef HALF_HANDSHAKE_RX_PROTO_CHK_EN
   logic proto_err_q;
   // Flags an abandoned pending transfer or a new request during an ack.
   always_ff @(posedge clk_receive or negedge rst_receive)
      if (!rst_receive) proto_err_q <= 1'b0;
      else if ((fall & pending_q) | (rise & (state_q == RX_ACK))) proto_err_q <= 1'b1;
   assign proto_err = proto_err_q;
`endif
endmodule
